// File: rtl/spa_engine.sv
// Floyd-Warshall all-pairs shortest-path engine over an N_VERT x N_VERT register matrix.
// Edges are loaded while idle; one relaxation per clock while running; registered query port.
module spa_engine #(
  parameter int unsigned N_VERT = 4,
  parameter int unsigned COST_W = 4,
  parameter int unsigned DIST_W = 8,
  parameter int unsigned ID_W   = $clog2(N_VERT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              edge_valid,
  input  logic [ID_W-1:0]   edge_src,
  input  logic [ID_W-1:0]   edge_dst,
  input  logic [COST_W-1:0] edge_cost,
  input  logic              clear,
  input  logic              start,
  input  logic [ID_W-1:0]   q_src,
  input  logic [ID_W-1:0]   q_dst,
  output logic [DIST_W-1:0] q_dist,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [DIST_W-1:0] INF  = '1;
  localparam logic [ID_W-1:0]   ONE  = ID_W'(1);
  localparam logic [ID_W-1:0]   LAST = ID_W'(N_VERT);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   k, i, j, k_next, i_next, j_next;
  logic              busy_next, done_next, err_next;
  logic              do_init, do_write, do_relax;

  // Row/column 0 are never addressed; IDs map directly onto indices 1..N_VERT.
  logic [DIST_W-1:0] d [N_VERT+1][N_VERT+1];

  logic              src_ok, dst_ok, qs_ok, qd_ok;
  logic [DIST_W-1:0] d_ik, d_kj, d_ij, via, relax_val;
  logic [DIST_W:0]   sum;

  assign src_ok = (edge_src != '0) && (edge_src <= LAST);
  assign dst_ok = (edge_dst != '0) && (edge_dst <= LAST);
  assign qs_ok  = (q_src != '0) && (q_src <= LAST);
  assign qd_ok  = (q_dst != '0) && (q_dst <= LAST);

  // Saturating relaxation candidate for the current (k, i, j)
  assign d_ik      = d[i][k];
  assign d_kj      = d[k][j];
  assign d_ij      = d[i][j];
  assign sum       = {1'b0, d_ik} + {1'b0, d_kj};
  assign via       = ((d_ik == INF) || (d_kj == INF) || (sum >= {1'b0, INF})) ? INF : sum[DIST_W-1:0];
  assign relax_val = (via < d_ij) ? via : d_ij;

  always_comb begin
    state_next = state;
    k_next     = k;
    i_next     = i;
    j_next     = j;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    do_init    = 1'b0;
    do_write   = 1'b0;
    do_relax   = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          do_init = 1'b1;
        end else if (edge_valid) begin
          if (!src_ok || !dst_ok) err_next = 1'b1;
          else if (edge_src != edge_dst) do_write = 1'b1;
        end else if (start) begin
          state_next = RUN;
          k_next     = ONE;
          i_next     = ONE;
          j_next     = ONE;
          busy_next  = 1'b1;
        end
      end
      RUN: begin
        do_relax  = 1'b1;
        busy_next = 1'b1;
        err_next  = edge_valid | clear;
        // j fastest, then i, then k
        if (j == LAST) begin
          j_next = ONE;
          if (i == LAST) begin
            i_next = ONE;
            if (k == LAST) begin
              state_next = IDLE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end else begin
              k_next = k + ONE;
            end
          end else begin
            i_next = i + ONE;
          end
        end else begin
          j_next = j + ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      k     <= ONE;
      i     <= ONE;
      j     <= ONE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      k     <= k_next;
      i     <= i_next;
      j     <= j_next;
      busy  <= busy_next;
      done  <= done_next;
      err   <= err_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || do_init) begin
      for (int r = 0; r <= int'(N_VERT); r++) begin
        for (int c = 0; c <= int'(N_VERT); c++) begin
          d[ID_W'(r)][ID_W'(c)] <= (r == c) ? '0 : INF;
        end
      end
    end else if (do_write) begin
      d[edge_src][edge_dst] <= DIST_W'(edge_cost);
    end else if (do_relax) begin
      d[i][j] <= relax_val;
    end
  end

  // Query samples the matrix as it stands before this edge's update
  always_ff @(posedge clock) begin
    if (reset) q_dist <= '0;
    else       q_dist <= (qs_ok && qd_ok) ? d[q_src][q_dst] : INF;
  end

endmodule

// File: tb/tb_spa_engine.sv
// Self-checking bench for spa_engine: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a whole-computation model.
module tb_spa_engine;

  localparam int N   = 4;
  localparam int INF = 255;

  logic       clock = 1'b0;
  logic       reset, edge_valid, clear, start;
  logic [2:0] edge_src, edge_dst, q_src, q_dst;
  logic [7:0] edge_cost;
  logic [7:0] q_dist;
  logic       busy, done, err;

  always #5 clock = ~clock;

  spa_engine #(.N_VERT(4), .COST_W(8), .DIST_W(8)) dut (
    .clock(clock), .reset(reset), .edge_valid(edge_valid), .edge_src(edge_src),
    .edge_dst(edge_dst), .edge_cost(edge_cost), .clear(clear), .start(start),
    .q_src(q_src), .q_dst(q_dst), .q_dist(q_dist), .busy(busy), .done(done), .err(err)
  );

  int total = 0;
  int bad   = 0;

  int m [5][5];
  int run_cnt = 0;
  int exp_q   = 0;
  bit exp_busy, exp_done, exp_err;
  bit live = 1'b0;

  task automatic chk(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  function automatic bit id_ok(input int id);
    return (id >= 1) && (id <= N);
  endfunction

  function automatic int sat(input int a, input int b);
    if (a == INF || b == INF || a + b >= INF) return INF;
    return a + b;
  endfunction

  function automatic void init_m();
    for (int r = 0; r <= N; r++)
      for (int c = 0; c <= N; c++)
        m[r][c] = (r == c) ? 0 : INF;
  endfunction

  // Whole all-pairs result computed at once when a run is accepted
  function automatic void floyd();
    for (int kk = 1; kk <= N; kk++)
      for (int ii = 1; ii <= N; ii++)
        for (int jj = 1; jj <= N; jj++) begin
          int v;
          v = sat(m[ii][kk], m[kk][jj]);
          if (v < m[ii][jj]) m[ii][jj] = v;
        end
  endfunction

  // Reference model, advanced on every sampling edge
  always @(posedge clock) begin
    if (reset) begin
      init_m();
      run_cnt  = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_q    = 0;
    end else begin
      exp_q    = (id_ok(int'(q_src)) && id_ok(int'(q_dst))) ? m[q_src][q_dst] : INF;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (run_cnt > 0) begin
        if (edge_valid || clear) exp_err = 1'b1;
        run_cnt--;
        if (run_cnt == 0) begin
          exp_busy = 1'b0;
          exp_done = 1'b1;
        end
      end else if (clear) begin
        init_m();
      end else if (edge_valid) begin
        if (!id_ok(int'(edge_src)) || !id_ok(int'(edge_dst))) exp_err = 1'b1;
        else if (edge_src != edge_dst) m[edge_src][edge_dst] = int'(edge_cost);
      end else if (start) begin
        floyd();
        run_cnt  = N * N * N;
        exp_busy = 1'b1;
      end
    end
    live = 1'b1;
  end

  // Per-cycle compare against the model
  always @(negedge clock) begin
    if (live) begin
      chk("busy", int'(busy), int'(exp_busy));
      chk("done", int'(done), int'(exp_done));
      chk("err", int'(err), int'(exp_err));
      if (!exp_busy) chk("q_dist", int'(q_dist), exp_q);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
    edge_valid = 1'b0;
    clear      = 1'b0;
    start      = 1'b0;
  endtask

  task automatic wr(input int s, input int d, input int c);
    edge_valid = 1'b1;
    edge_src   = 3'(s);
    edge_dst   = 3'(d);
    edge_cost  = 8'(c);
    cyc();
  endtask

  task automatic query(input int s, input int d);
    q_src = 3'(s);
    q_dst = 3'(d);
    cyc();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
  endtask

  // Counts cycles from the start edge to the done pulse (bounded)
  task automatic wait_done(input int already, output int n);
    n = already;
    while (!done && n < 200) begin
      cyc();
      n++;
    end
  endtask

  task automatic run(output int n);
    start = 1'b1;
    cyc();
    wait_done(0, n);
  endtask

  task automatic basic_graph();
    wr(1, 3, 3);
    wr(3, 4, 1);
    wr(2, 1, 2);
  endtask

  int n;

  initial begin
    reset = 1'b1; edge_valid = 1'b0; clear = 1'b0; start = 1'b0;
    edge_src = '0; edge_dst = '0; edge_cost = '0; q_src = 3'd1; q_dst = 3'd1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_q_dist", int'(q_dist), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    query(1, 1); chk("init_q11", int'(q_dist), 0);
    query(1, 2); chk("init_q12", int'(q_dist), 255);

    // Basic graph
    basic_graph();
    run(n);
    chk("basic_latency", n, 64);
    chk("model_24", m[2][4], 6);
    query(2, 4); chk("basic_q24", int'(q_dist), 6);
    query(1, 4); chk("basic_q14", int'(q_dist), 4);
    query(2, 3); chk("basic_q23", int'(q_dist), 5);
    query(4, 1); chk("basic_q41", int'(q_dist), 255);
    query(3, 3); chk("basic_q33", int'(q_dist), 0);

    // Overwrite and rerun, then clear
    wr(1, 3, 1);
    run(n);
    query(2, 4); chk("rerun_q24", int'(q_dist), 4);
    do_clear();
    query(2, 4); chk("clear_q24", int'(q_dist), 255);

    // Saturation
    wr(1, 2, 200); wr(2, 3, 100);
    run(n);
    query(1, 3); chk("sat_q13", int'(q_dist), 255);
    do_clear();
    wr(1, 2, 200); wr(2, 3, 54);
    run(n);
    chk("model_13", m[1][3], 254);
    query(1, 3); chk("near_sat_q13", int'(q_dist), 254);

    // Rejections in IDLE and during RUN
    do_clear();
    basic_graph();
    edge_valid = 1'b1; edge_src = 3'd0; edge_dst = 3'd2; edge_cost = 8'd1;
    cyc();
    chk("err_src0", int'(err), 1);
    start = 1'b1;
    cyc();
    repeat (9) cyc();
    edge_valid = 1'b1; edge_src = 3'd2; edge_dst = 3'd4; edge_cost = 8'd0;
    cyc();
    chk("err_run_edge", int'(err), 1);
    clear = 1'b1;
    cyc();
    chk("err_run_clear", int'(err), 1);
    start = 1'b1;
    cyc();
    wait_done(12, n);
    chk("noisy_latency", n, 64);
    query(2, 4); chk("noisy_q24", int'(q_dist), 6);

    // Reset mid-run
    do_clear();
    basic_graph();
    start = 1'b1;
    cyc();
    repeat (29) cyc();
    reset = 1'b1;
    cyc();
    chk("midrst_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (70) cyc();
    query(2, 4); chk("midrst_q24", int'(q_dist), 255);

    // Randomized traffic
    repeat (2000) begin
      edge_valid = ($urandom_range(0, 9) < 4);
      edge_src   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
      edge_dst   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
      edge_cost  = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 120));
      clear      = ($urandom_range(0, 99) < 2);
      start      = ($urandom_range(0, 99) < 5);
      q_src      = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
      q_dst      = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
      @(posedge clock);
      #1;
    end
    edge_valid = 1'b0; clear = 1'b0; start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
    end
    chk("drain_idle", int'(busy), 0);
    for (int s = 1; s <= N; s++)
      for (int d = 1; d <= N; d++) query(s, d);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
